// File: rtl/reg_file_dump_ctrl_if.sv
// Command, register-file port and dump-stream signals of the register file
// fill/dump controller.
interface reg_file_dump_ctrl_if #(
  parameter int ADW = 5,
  parameter int DPW = 32
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_op;
  logic [DPW-1:0] cmd_data;

  logic [ADW-1:0] rf_addr_rd;
  logic [DPW-1:0] rf_rd;
  logic           rf_we;
  logic [ADW-1:0] rf_addr_wr;
  logic [DPW-1:0] rf_wd;

  logic           out_valid;
  logic           out_ready;
  logic [DPW-1:0] out_data;
  logic [ADW-1:0] out_addr;
  logic           out_last;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, rf_rd, out_ready,
    output cmd_ready, rf_addr_rd, rf_we, rf_addr_wr, rf_wd,
    output out_valid, out_data, out_addr, out_last
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, rf_rd, out_ready,
    input  cmd_ready, rf_addr_rd, rf_we, rf_addr_wr, rf_wd,
    input  out_valid, out_data, out_addr, out_last
  );
endinterface

// File: rtl/reg_file_dump_ctrl.sv
// Debug-path sequencer that fills every register with one value or dumps every
// register onto a valid/ready stream, allowing for the one-cycle read latency.
module reg_file_dump_ctrl #(
  parameter int ADW = 5,
  parameter int DPW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_file_dump_ctrl_if.master bus,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADW-1:0] LAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RD,
    CAP,
    OUT
  } state_t;

  state_t         state;
  logic [ADW-1:0] idx;
  logic [DPW-1:0] fill_val;
  logic           out_valid_q;
  logic [DPW-1:0] out_data_q;
  logic [ADW-1:0] out_addr_q;
  logic           out_last_q;
  logic           done_q;

  // Decoded straight from the async-reset state so rf_we drops without a clock.
  assign bus.cmd_ready  = (state == IDLE);
  assign busy           = (state != IDLE);
  assign bus.rf_we      = (state == FILL);
  assign bus.rf_addr_rd = idx;
  assign bus.rf_addr_wr = idx;
  assign bus.rf_wd      = fill_val;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_last   = out_last_q;
  assign done           = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      fill_val    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            idx      <= '0;
            fill_val <= bus.cmd_data;
            state    <= bus.cmd_op ? RD : FILL;
          end
        end
        FILL: begin
          if (idx == LAST) begin
            idx    <= '0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          out_data_q  <= bus.rf_rd;
          out_addr_q  <= idx;
          out_last_q  <= (idx == LAST);
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          // Terminal check precedes the increment so idx never wraps mid-dump.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (idx == LAST) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
